md_sequencer: RTL and testbench

- Multiply/divide unit with its own sequencer, placed in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo requests and models fixed multi-cycle latency with a busy counter.
- Owns the HI/LO architectural registers.
- Exposes start/busy to the stall controller, which stalls any MD instruction in D while start|busy.
- Honours a cancel input from the exception/interrupt logic so a cancelled instruction never alters HI/LO.

---
 rtl/md_sequencer.sv | 164 ++++++++++++++++
 tb/tb_md_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : E-stage multiply/divide unit. It owns HI/LO and models a fixed
//            multi-cycle latency with a busy counter. The result is computed
//            at accept time, held as pending, and committed when the count
//            expires.
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        phi_q, phi_d;
  logic [31:0]        plo_q, plo_d;
  logic               pv_q, pv_d;     // pending result must be written at completion

  logic               op_legal;
  logic               op_long;
  logic               accept;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        mag_a, mag_b, div_b;
  logic [31:0]        uq, ur;
  logic [31:0]        quo, rem;

  assign op_legal = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
  assign op_long  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign accept   = md_valid && !cancel && (state_q == S_IDLE) && op_legal;
  assign start    = accept && op_long;
  assign busy     = (state_q == S_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Products: sign- or zero-extended 64x64 multiply, truncated to 64 bits
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Division shares one unsigned divider. Signed div works on magnitudes, so
  // 0x80000000 / -1 cannot overflow. A zero divisor is replaced by 1 to keep
  // the datapath defined; that result is never committed.
  assign div_signed = (md_op == OP_DIV);
  assign mag_a      = (div_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign mag_b      = (div_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  assign div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / div_b;
  assign ur         = mag_a % div_b;
  assign quo        = (div_signed && (rs_data[31] ^ rt_data[31])) ? (32'd0 - uq) : uq;
  assign rem        = (div_signed && rs_data[31]) ? (32'd0 - ur) : ur;

  // Next-state logic: accept in IDLE, count down and commit in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pv_d    = pv_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (md_op)
            OP_MULT: begin
              phi_d   = prod_s[63:32];
              plo_d   = prod_s[31:0];
              pv_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_MULTU: begin
              phi_d   = prod_u[63:32];
              plo_d   = prod_u[31:0];
              pv_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              phi_d   = rem;
              plo_d   = quo;
              pv_d    = (rt_data != 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (pv_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          pv_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pv_q    <= pv_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Self-checking bench for md_sequencer. A behavioural model tracks
//            HI/LO and remaining busy cycles; directed cases and random
//            traffic are compared every cycle, plus literal result checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        md_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic        cancel = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pv;
  int          m_left;

  md_sequencer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
    .cancel(cancel), .rs_data(rs_data), .rt_data(rt_data),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions
  task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_pv = 1; m_left = MULT_CYCLES; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; m_phi = pu[63:32]; m_plo = pu[31:0]; m_pv = 1; m_left = MULT_CYCLES; end
      3'd3: begin
        m_left = DIV_CYCLES; m_pv = (b != 0);
        if (b != 0) begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
      end
      3'd4: begin
        m_left = DIV_CYCLES; m_pv = (b != 0);
        if (b != 0) begin m_plo = a / b; m_phi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pv = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (m_left == 1 && m_pv) begin m_hi = m_phi; m_lo = m_plo; end
      m_left--;
    end else if (md_valid && !cancel && md_op >= 3'd1 && md_op <= 3'd6) begin
      model_accept(md_op, rs_data, rt_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("start", start, md_valid && !cancel && (m_left == 0) && md_op >= 3'd1 && md_op <= 3'd4);
      chk("busy", busy, m_left > 0);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic drive(input bit v, input logic [2:0] op, input bit c,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_valid = v; md_op = op; cancel = c; rs_data = a; rt_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 3'd0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;

    // mult -2 * 3
    drive(1, 3'd1, 0, 32'hFFFFFFFE, 32'd3);
    #1 chk("mult_start", start, 1);
    idle(1);
    #1 chk("mult_busy", busy, 1);
    chk("mult_hold_hi", hi, 0);
    idle(5);
    #1 chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_done", busy, 0);

    // multu
    drive(1, 3'd2, 0, 32'hFFFFFFFF, 32'd2);
    idle(6);
    #1 chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2
    drive(1, 3'd3, 0, 32'hFFFFFFF9, 32'd2);
    idle(10);
    #1 chk("div_busy_end", busy, 1);
    idle(1);
    #1 chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // divu by zero leaves HI/LO alone
    drive(1, 3'd4, 0, 32'd7, 32'd0);
    idle(11);
    #1 chk("div0_lo", lo, 32'hFFFFFFFD);
    chk("div0_hi", hi, 32'hFFFFFFFF);

    // most-negative / -1
    drive(1, 3'd3, 0, 32'h80000000, 32'hFFFFFFFF);
    idle(11);
    #1 chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    // mthi then mtlo back-to-back
    drive(1, 3'd5, 0, 32'h12345678, 32'd0);
    #1 chk("mthi_start", start, 0);
    drive(1, 3'd6, 0, 32'h9ABCDEF0, 32'd0);
    #1 chk("mthi_hi", hi, 32'h12345678);
    idle(1);
    #1 chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mt_busy", busy, 0);

    // cancelled mult
    drive(1, 3'd1, 1, 32'd5, 32'd6);
    #1 chk("cancel_start", start, 0);
    idle(2);
    #1 chk("cancel_busy", busy, 0);
    chk("cancel_lo", lo, 32'h9ABCDEF0);

    // cancel pulse and ignored request during RUN
    drive(1, 3'd1, 0, 32'd6, 32'd7);
    idle(1);
    drive(0, 3'd0, 1, 32'd0, 32'd0);
    drive(1, 3'd2, 1, 32'd9, 32'd9);
    drive(1, 3'd6, 0, 32'hDEADBEEF, 32'd9);
    #1 chk("busy_req_start", start, 0);
    idle(2);
    #1 chk("runcancel_lo", lo, 32'd42);
    chk("runcancel_hi", hi, 32'd0);

    // asynchronous reset mid-RUN
    drive(1, 3'd3, 0, 32'd1000, 32'd3);
    idle(2);
    drive(1, 3'd3, 0, 32'd50, 32'd5);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    idle(1);
    reset = 1'b1;
    drive(1, 3'd3, 0, 32'd100, 32'd7);
    idle(11);
    #1 chk("div100_lo", lo, 32'd14);
    chk("div100_hi", hi, 32'd2);

    // random traffic, including requests while busy and zero divisors
    repeat (600) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          (($urandom_range(0, 1) == 0) ? 32'(-$urandom_range(1, 20)) : $urandom);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, a, b);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
